// File: rtl/fifo_lane_ctrl.sv
// fifo_lane_ctrl: byte-lane / longword sequencer in front of the FIFO full/empty counter.
// Latency: INCFIFO/DECFIFO are registered, one cycle after the completing op. LANE_WE is combinational.
// Backpressure: strobes are gated by FIFOFULL/FIFOEMPTY/BUSY. Gated strobes are dropped. Optional ERR via FIFO_LANE_ERR_EN.
module fifo_lane_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  CLK,
  input  logic                  RST_FIFO_,
  input  logic                  DIR,
  input  logic                  SCSI_WR_STB,
  input  logic                  SCSI_RD_STB,
  input  logic                  HOST_WR,
  input  logic                  HOST_RD,
  input  logic                  FLUSH,
  input  logic                  FIFOFULL,
  input  logic                  FIFOEMPTY,
  output logic                  INCFIFO,
  output logic                  DECFIFO,
  output logic [1:0]            BYTE_PTR,
  output logic [3:0]            LANE_WE,
  output logic [DEPTH_LOG2-1:0] WPTR,
  output logic [DEPTH_LOG2-1:0] RPTR,
  output logic                  BUSY,
  output logic                  ERR
);

  logic                  r_dir;
  logic [1:0]            r_byte_ptr;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic                  r_inc;
  logic                  r_dec;
  logic                  r_pend;

  logic       w_dir_chg;
  logic [1:0] w_lane;
  logic       w_wr_acc;
  logic       w_rd_acc;
  logic       w_hwr_acc;
  logic       w_hrd_acc;
  logic       w_byte_acc;
  logic [1:0] w_lane_nxt;
  logic       w_wrap;
  logic       w_flush_cl;
  logic       w_inc_new;
  logic       w_dec_new;
  logic       w_inc_req;
  logic [1:0] w_ptr_nxt;

  // A direction change discards any partial longword.
  // The new direction starts at lane 0 in the same cycle.
  assign w_dir_chg  = (DIR != r_dir);
  assign w_lane     = w_dir_chg ? 2'd0 : r_byte_ptr;

  // Accept qualification. HOST_WR is also held off while an INC is parked.
  assign w_wr_acc   = SCSI_WR_STB &  DIR & ~FIFOFULL;
  assign w_rd_acc   = SCSI_RD_STB & ~DIR & ~FIFOEMPTY;
  assign w_hwr_acc  = HOST_WR     & ~DIR & ~FIFOFULL & ~r_pend;
  assign w_hrd_acc  = HOST_RD     &  DIR & ~FIFOEMPTY;
  assign w_byte_acc = w_wr_acc | w_rd_acc;

  // Lane advance. A FLUSH that leaves a partial longword closes it early.
  assign w_lane_nxt = w_lane + {1'b0, w_byte_acc};
  assign w_wrap     = w_byte_acc & (w_lane == 2'd3);
  assign w_flush_cl = FLUSH & DIR & (w_lane_nxt != 2'd0);
  assign w_ptr_nxt  = w_flush_cl ? 2'd0 : w_lane_nxt;

  // Entry completions this cycle. The two directions can never both complete the same way.
  assign w_inc_new  = (w_wrap & DIR) | w_flush_cl | w_hwr_acc;
  assign w_dec_new  = (w_wrap & ~DIR) | w_hrd_acc;
  assign w_inc_req  = r_pend | w_inc_new;

  assign LANE_WE  = w_wr_acc ? (4'b1000 >> w_lane) : 4'b0000;
  assign BYTE_PTR = w_lane;
  assign WPTR     = r_wptr;
  assign RPTR     = r_rptr;
  assign INCFIFO  = r_inc;
  assign DECFIFO  = r_dec;
  assign BUSY     = r_pend;

  // Byte lane, direction tracking and entry pointers.
  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      r_dir      <= 1'b0;
      r_byte_ptr <= 2'd0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_dir      <= DIR;
      r_byte_ptr <= w_ptr_nxt;
      if (w_inc_new) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_dec_new) r_rptr <= r_rptr + DEPTH_LOG2'(1);
    end
  end

  // Pulse issue. The counter drops INC when DEC is present, so DEC wins a collision.
  // The INC is parked and issued on the next cycle free of DEC.
  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      r_inc  <= 1'b0;
      r_dec  <= 1'b0;
      r_pend <= 1'b0;
    end else if (w_dec_new) begin
      r_dec  <= 1'b1;
      r_inc  <= 1'b0;
      r_pend <= w_inc_req;
    end else begin
      r_dec  <= 1'b0;
      r_inc  <= w_inc_req;
      r_pend <= r_pend & w_inc_new;
    end
  end

`ifdef FIFO_LANE_ERR_EN
  logic r_err;
  logic w_drop;
  logic w_discard;
  logic w_busy_op;

  assign w_drop    = (SCSI_WR_STB &  DIR & FIFOFULL)
                   | (SCSI_RD_STB & ~DIR & FIFOEMPTY)
                   | (HOST_WR     & ~DIR & (FIFOFULL | r_pend))
                   | (HOST_RD     &  DIR & FIFOEMPTY);
  assign w_discard = w_dir_chg & (r_byte_ptr != 2'd0);
  assign w_busy_op = r_pend & (w_inc_new | w_dec_new);
  assign ERR       = r_err;

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) r_err <= 1'b0;
    else            r_err <= r_err | w_drop | w_discard | w_busy_op;
  end
`else
  assign ERR = 1'b0;
`endif

endmodule
